// File: rtl/share_arb_pkg.sv
// Shared types and helpers for the share_arbiter block: FSM state type,
// channel count and one-hot/index conversion functions.
package share_arb_pkg;

  localparam int SHARE_ARB_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } share_arb_state_t;

  // Channel index (0 = channel 1) to one-hot grant vector.
  function automatic logic [SHARE_ARB_NREQ-1:0] idxToOneHot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // One-hot grant vector to channel index; lowest set bit wins if not one-hot.
  function automatic logic [1:0] oneHotToIdx(input logic [SHARE_ARB_NREQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = SHARE_ARB_NREQ - 1; i >= 0; i--) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/share_arb_rr_pick.sv
// Combinational round-robin picker: scans channels starting one past the
// most recent owner, wrapping, and returns the first requesting channel.
module share_arb_rr_pick
  import share_arb_pkg::*;
(
  input  logic [SHARE_ARB_NREQ-1:0] reqVec,
  input  logic [1:0]                last,
  output logic                      valid,
  output logic [1:0]                winner
);

  logic [1:0] cand;

  // Rotating priority scan; the previous owner is checked last.
  always_comb begin
    valid  = 1'b0;
    winner = 2'd0;
    cand   = 2'd0;
    for (int i = 1; i <= SHARE_ARB_NREQ; i++) begin
      cand = last + 2'(i);
      if (!valid && reqVec[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/share_arbiter.sv
// Round-robin owner arbiter for the shared word memory port.
// Issues one-hot busy_1..busy_4 grants with a programmable all-idle gap
// between owners so the distributor's registered outputs drain to zero.
// Optional feature macro: SHARE_ARB_TIMEOUT_EN (hold counter + preemption).
module share_arbiter
  import share_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_1,
  input  logic       req_2,
  input  logic       req_3,
  input  logic       req_4,
  output logic       busy_1,
  output logic       busy_2,
  output logic       busy_3,
  output logic       busy_4,
  output logic [1:0] grant_id,
  output logic       idle,
  output logic       preempt,
  output logic [1:0] stateDbg
);

  // Handshake: a channel raises req_k and waits; busy_k rises one edge after
  // the request is sampled and stays high while req_k stays high. Dropping
  // req_k releases ownership at the next edge. A request dropped before its
  // busy_k rises is forgotten. busy_k falling while req_k is still high
  // (preemption) is an abort the owner must honour.

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_params
    $error("share_arbiter: GAP_CYCLES or MAX_HOLD out of range");
  end

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [SHARE_ARB_NREQ-1:0] reqVec;
  share_arb_state_t          state, nextState;
  logic [1:0]                lastQ, lastD;
  logic [1:0]                grantIdQ, grantIdD;
  logic [1:0]                pickIdx;
  logic                      pickValid;
  logic [3:0]                gapCnt, gapD;
  logic [SHARE_ARB_NREQ-1:0] busyQ, busyD;
  logic                      idleQ, idleD;
  logic                      timeoutHit;

  assign reqVec = {req_4, req_3, req_2, req_1};

  share_arb_rr_pick uPick (
    .reqVec (reqVec),
    .last   (lastQ),
    .valid  (pickValid),
    .winner (pickIdx)
  );

`ifdef SHARE_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

  logic [15:0] holdCnt;
  logic        othersReq;
  logic        preemptQ;

  assign othersReq  = |(reqVec & ~idxToOneHot(grantIdQ));
  assign timeoutHit = (holdCnt == HOLD_LAST) && othersReq;

  // Hold counter: zero outside GRANT, counts grant cycles, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdCnt <= 16'd0;
    end else if (state != GRANT) begin
      holdCnt <= 16'd0;
    end else if (holdCnt != HOLD_LAST) begin
      holdCnt <= holdCnt + 16'd1;
    end
  end

  // Preempt pulse: the owner still wanted the port but was forced out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preemptQ <= 1'b0;
    end else begin
      preemptQ <= (state == GRANT) && reqVec[grantIdQ] && timeoutHit;
    end
  end

  assign preempt = preemptQ;
`else
  assign timeoutHit = 1'b0;
  assign preempt    = 1'b0;
`endif

  // Next-state, next-owner and next-output decode.
  always_comb begin
    nextState = state;
    lastD     = lastQ;
    gapD      = gapCnt;
    busyD     = busyQ;
    grantIdD  = grantIdQ;
    case (state)
      IDLE: begin
        busyD = '0;
        if (pickValid) begin
          nextState = GRANT;
          busyD     = idxToOneHot(pickIdx);
          grantIdD  = pickIdx;
        end
      end
      GRANT: begin
        if (!reqVec[grantIdQ] || timeoutHit) begin
          nextState = GAP;
          busyD     = '0;
          lastD     = grantIdQ;
          gapD      = GAP_LOAD;
        end
      end
      GAP: begin
        busyD = '0;
        if (gapCnt != 4'd0) begin
          gapD = gapCnt - 4'd1;
        end else if (pickValid) begin
          nextState = GRANT;
          busyD     = idxToOneHot(pickIdx);
          grantIdD  = pickIdx;
        end else begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
        busyD     = '0;
      end
    endcase
    idleD = (nextState == IDLE);
  end

  // State, pointer, gap counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lastQ    <= 2'd3;
      gapCnt   <= 4'd0;
      busyQ    <= '0;
      grantIdQ <= 2'd0;
      idleQ    <= 1'b1;
    end else begin
      state    <= nextState;
      lastQ    <= lastD;
      gapCnt   <= gapD;
      busyQ    <= busyD;
      grantIdQ <= grantIdD;
      idleQ    <= idleD;
    end
  end

  assign busy_1   = busyQ[0];
  assign busy_2   = busyQ[1];
  assign busy_3   = busyQ[2];
  assign busy_4   = busyQ[3];
  assign grant_id = grantIdQ;
  assign idle     = idleQ;
  assign stateDbg = state;

endmodule

// File: doc/share_arbiter.md
# share_arbiter

Round-robin arbiter that owns the shared word memory port and issues the one-hot `busy_1`..`busy_4` grants to the four processing channels. Those grants drive the common-port distributor. Each channel raises a request, receives exclusive ownership, keeps it while the request stays high, and releases it by dropping the request. A programmable dead gap between owners lets the distributor's registered outputs drain to zero before the next owner takes the port.

## Interface
Parameters:
- `GAP_CYCLES`, default 1: number of all-idle cycles between any two grants. Legal range 1..15.
- `MAX_HOLD`, default 256: grant cycles before preemption is allowed. Used only with `SHARE_ARB_TIMEOUT_EN`. Legal range 2..65535.

Ports (reset is asynchronous, active-low; clock is `clk`):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `req_1`..`req_4`  in  1 each  channel request for the common port
- `busy_1`..`busy_4`  out  1 each  one-hot grant; at most one is high in any cycle
- `grant_id`  out  2  index of the current or most recent owner (0 = channel 1)
- `idle`  out  1  high when no grant is active and no gap is running
- `preempt`  out  1  one-cycle pulse when a grant is force-released

## Operation
- State machine with three states: IDLE, GRANT, GAP.
- Reset values:
  - all `busy_*` = 0, `grant_id` = 0, `idle` = 1, `preempt` = 0
  - state = IDLE, internal `last` pointer = 3, so channel 1 has first priority
  - gap counter = 0, hold counter = 0
- Round-robin pick: scan channels starting at `(last+1) mod 4`, wrapping; the first channel with its request high wins.
- IDLE:
  - Any request high: grant the pick, go to GRANT, load `grant_id`.
  - No request high: stay in IDLE.
- GRANT (owner k):
  - `req_k` high: hold `busy_k`. Requests from other channels are ignored.
  - `req_k` low: drop `busy_k`, set `last` = k, load the gap counter with `GAP_CYCLES`-1, go to GAP.
- GAP:
  - All `busy_*` = 0 and `idle` = 0.
  - Counter above 0: decrement.
  - Counter at 0 and any request high: grant the pick directly (GAP -> GRANT).
  - Counter at 0 and no request high: go to IDLE.
- A request that drops before it is granted is never granted.
- Owner k re-requesting is legal. Its priority is last in the rotation.
- `grant_id` holds its value through GAP and IDLE.
- Reset asserted mid-grant clears `busy_*` asynchronously. `last` returns to 3.

## Timing
- Requests are sampled at each rising edge. `busy` changes are registered, so latency from request to grant is 1 cycle.
- Release: `req_k` seen low at edge t means `busy_k` is low after edge t.
- The next grant appears no earlier than edge t+`GAP_CYCLES`. With the default, there is exactly 1 zero cycle between owners.
- Simultaneous requests resolve in a single cycle by rotation. There is no extra latency for contention.
- A requester must keep its request high until its final memory access has propagated through the distributor's register stage. That is 1 cycle after its last access.

## Configuration
- `SHARE_ARB_TIMEOUT_EN` defined:
  - The hold counter clears on entry to GRANT and increments each GRANT cycle, saturating at `MAX_HOLD`-1.
  - Preemption fires when the counter is at `MAX_HOLD`-1 and any other channel's request is high. On that edge `busy_k` drops, `preempt` pulses for 1 cycle, `last` = k, and the block enters GAP.
  - A saturated owner with no competitor keeps the grant indefinitely.
  - The owner is required to treat `busy_k` falling as an abort. It may re-request.
- `SHARE_ARB_TIMEOUT_EN` not defined: no hold counter is built, `preempt` is tied to 0, and a grant lasts until the owner releases it.

## Structure
- Package `share_arb_pkg` contains:
  - state typedef `share_arb_state_t` (IDLE, GRANT, GAP)
  - constant `SHARE_ARB_NREQ` = 4
  - one-hot/index conversion functions
- One sub-module, `share_arb_rr_pick`. It is combinational: a 4-bit request vector and a 2-bit `last` go in; a `valid` flag and a 2-bit winner index come out. Instantiated once.
- The top level contains the state register, gap counter, hold counter (macro-guarded), `last` register and output registers.

## Test plan
- Reset, then `req_2` = 1: `busy_2` = 1 one cycle later and `grant_id` = 1. `req_2` = 0: `busy_2` drops next edge, 1 idle-gap cycle, then `idle` = 1.
- `req_1`..`req_4` all high from reset: grants go 1, 2, 3, 4, 1, with each owner dropping its request after 5 cycles. Each handover has exactly `GAP_CYCLES` zero cycles, and the one-hot check never fails.
- Owner 3 releases and re-requests while `req_1` is high, with `GAP_CYCLES`=3: 3 zero cycles, then `busy_4` stays 0 and `busy_1` = 1, because 3 is now lowest priority.
- `req_4` pulses high for 1 cycle while channel 1 owns the port: channel 4 is never granted.
- With `SHARE_ARB_TIMEOUT_EN` and `MAX_HOLD`=8: owner 1 holds, `req_2` rises at cycle 3. On the grant's 8th cycle `busy_1` falls, `preempt` = 1 for one cycle, and `busy_2` = 1 after the gap. With no competitor, owner 1 holds past 8 cycles and `preempt` = 0.
- Reset pulsed low mid-grant of channel 3: `busy_3` = 0 immediately. After release, `req_3` and `req_1` both high: channel 1 is granted first.
